// File: rtl/sk_adder_pkg.sv
// Shared definitions for the Sklansky adder arbiter slice: default operand
// width, adder pipeline depth and the tag-pipeline entry type.
package sk_adder_pkg;

  // Operand/sum width of the shared adder.
  localparam int WIDTH_DEF = 64;

  // Pipeline depth of SKadder_64; must match its register stage count.
  localparam int LAT_DEF = 4;

  // Widest tag needed for up to 16 requesters.
  localparam int TAG_MAX_W = 4;

  // One tag-pipeline stage: valid flag plus the issuing requester index.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/sk_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant combinationally from req and the
// last-winner pointer; the pointer advances to the winner on a handshake.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] win;
  logic [TAG_W-1:0] idx;
  logic             found;

  // Search from ptr+1 upward, wrapping, and grant the first active request.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    gnt   = '0;
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = TAG_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
  end

  // Pointer register; starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      ptr <= TAG_W'(NUM_REQ - 1);
    end else if (adv) begin
      ptr <= win;
    end
  end

endmodule

// File: rtl/sk_adder_arbiter.sv
// Round-robin front-end sharing one pipelined Sklansky adder among NUM_REQ
// requesters. Registers the winner's operands toward the adder, carries the
// requester tag down a LAT+1 stage pipeline and steers each result back.
// Optional feature macro: SK_ADDER_ARB_STATS_EN adds per-requester 32-bit
// saturating grant counters on output grant_cnt.
module sk_adder_arbiter
  import sk_adder_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = WIDTH_DEF,
  parameter  int LAT     = LAT_DEF,
  localparam int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
`ifdef SK_ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]    grant_cnt
`endif
);

  logic [NUM_REQ-1:0] gnt;
  logic               hs;
  logic [TAG_W-1:0]   win_idx;
  tag_entry_t         pipe [LAT+1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .adv   (hs),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  // Encode the one-hot grant into the winner index for operand mux and tag.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_idx = TAG_W'(i);
    end
  end

  // Register the winner's operands toward the adder; hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else if (hs) begin
      add_a   <= req_a[win_idx*WIDTH +: WIDTH];
      add_b   <= req_b[win_idx*WIDTH +: WIDTH];
      add_cin <= req_cin[win_idx];
    end
  end

  // Free-running tag pipeline; stage LAT lines up with add_sum/add_cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole pipeline is reset so in-flight tags are dropped on reset;
      // only the valid bits matter, the tags are cleared alongside for simplicity.
      for (int s = 0; s <= LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{valid: hs, tag: TAG_MAX_W'(win_idx)};
      for (int s = 1; s <= LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  // Steer the aligned adder result to its requester as a one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= pipe[LAT].valid ? (NUM_REQ'(1) << pipe[LAT].tag) : '0;
      rsp_sum   <= add_sum;
      rsp_cout  <= add_cout;
    end
  end

`ifdef SK_ADDER_ARB_STATS_EN
  // Per-requester handshake counters that stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && req_valid[i] && grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF) begin
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sk_adder_arbiter.sv
// Directed bench for sk_adder_arbiter with a 4-stage behavioural adder
// standing in for SKadder_64. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_sk_adder_arbiter;
  import sk_adder_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;
  localparam int LAT     = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_cin;
  logic [WIDTH-1:0]         add_sum;
  logic                     add_cout;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
`ifdef SK_ADDER_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]    grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sk_adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef SK_ADDER_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Behavioural LAT-stage adder: {cout,sum} valid LAT edges after operands.
  logic [WIDTH:0] adder_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    for (int s = 1; s < LAT; s++) adder_pipe[s] <= adder_pipe[s-1];
  end
  assign {add_cout, add_sum} = adder_pipe[LAT-1];

  // Expected response tables, hand-computed per cycle after the first grant.
  logic [3:0]  t2_v [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [63:0] t2_s [10] = '{0, 0, 0, 0, 0, 0, 11, 22, 33, 0};
  logic [3:0]  t3_v [8]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};
  logic [63:0] t3_s [8]  = '{0, 0, 0, 0, 0, 0, 13, 0};
  logic        t3_c [8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
  logic [3:0]  t4_v [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h8, 4'h0, 4'h2, 4'h0};
  logic [63:0] t4_s [10] = '{0, 0, 0, 0, 0, 101, 304, 0, 101, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the strobe; sum and carry only matter while a strobe is expected.
  task automatic check_rsp(input string tag, input logic [3:0] v, input logic [63:0] s,
                           input logic c);
    check({tag, "_v"}, 64'(rsp_valid), 64'(v));
    if (v != 4'h0) begin
      check({tag, "_sum"}, rsp_sum, s);
      check({tag, "_cout"}, 64'(rsp_cout), 64'(c));
    end
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]              = c;
  endtask

  task pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_add_a", add_a, 64'h0);
    check("rst_add_b", add_b, 64'h0);
    check("rst_add_cin", 64'(add_cin), 64'h0);
    check("rst_rsp_sum", rsp_sum, 64'h0);
    check("rst_rsp_cout", 64'(rsp_cout), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: requester 0 alone, 0 + 200.
    set_req(0, 64'd0, 64'd200, 1'b0);
    req_valid = 4'b0001;
    #1 check("t1_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    check("t1_add_b", add_b, 64'd200);
    for (int j = 0; j <= LAT; j++) begin
      check_rsp($sformatf("t1_c%0d", j), 4'h0, 64'd0, 1'b0);
      @(negedge clk);
    end
    check_rsp("t1_hit", 4'h1, 64'd200, 1'b0);
    @(negedge clk);
    check_rsp("t1_after", 4'h0, 64'd0, 1'b0);

    // T2: all four requesting from a fresh pointer; a=i, b=10*i.
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 64'(i), 64'(10 * i), 1'b0);
    req_valid = 4'b1111;
    #1 check("t2_ready_init", 64'(req_ready), 64'h1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 3) check($sformatf("t2_ready_c%0d", cyc), 64'(req_ready), 64'(4'h2 << cyc));
      if (cyc == 3) begin
        check("t2_ready_wrap", 64'(req_ready), 64'h1);
        req_valid = '0;
      end
      check_rsp($sformatf("t2_c%0d", cyc), t2_v[cyc], t2_s[cyc], 1'b0);
    end

    // T3: requester 2, all-ones + 1 then 5 + 7 + 1, back to back.
    set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    req_valid = 4'b0100;
    #1 check("t3_ready", 64'(req_ready), 64'h4);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("t3_add_a0", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_add_cin0", 64'(add_cin), 64'h0);
        set_req(2, 64'd5, 64'd7, 1'b1);
        check("t3_ready_again", 64'(req_ready), 64'h4);
      end
      if (cyc == 1) begin
        req_valid = '0;
        check("t3_add_a1", add_a, 64'd5);
        check("t3_add_cin1", 64'(add_cin), 64'h1);
      end
      check_rsp($sformatf("t3_c%0d", cyc), t3_v[cyc], t3_s[cyc], t3_c[cyc]);
    end

    // T4: requesters 1 and 3 with the pointer at 3, then an idle gap, then 1.
    pulse_reset();
    set_req(1, 64'd100, 64'd1, 1'b0);
    set_req(3, 64'd300, 64'd3, 1'b1);
    req_valid = 4'b1010;
    #1 check("t4_ready_init", 64'(req_ready), 64'h2);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("t4_ready_c0", 64'(req_ready), 64'h8);
      if (cyc == 1) begin
        check("t4_ready_c1", 64'(req_ready), 64'h2);
        req_valid = '0;
      end
      if (cyc == 2) begin
        check("t4_ready_gap", 64'(req_ready), 64'h0);
        req_valid = 4'b0010;
      end
      if (cyc == 3) req_valid = '0;
      check_rsp($sformatf("t4_c%0d", cyc), t4_v[cyc], t4_s[cyc], 1'b0);
    end

    // T5: three results in flight from requester 0, one-cycle reset, then a new one.
    set_req(0, 64'd7, 64'd8, 1'b0);
    req_valid = 4'b0001;
    #1 check("t5_ready_init", 64'(req_ready), 64'h1);
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc < 2) check($sformatf("t5_ready_c%0d", cyc), 64'(req_ready), 64'h1);
      if (cyc == 2) begin
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("t5_inrst_v", 64'(rsp_valid), 64'h0);
        check("t5_inrst_add_a", add_a, 64'h0);
      end
      if (cyc == 3) rst_n = 1'b1;
      if (cyc >= 3) check($sformatf("t5_flush_c%0d", cyc), 64'(rsp_valid), 64'h0);
    end
    req_valid = 4'b0011;
    #1 check("t5_ready_new", 64'(req_ready), 64'h1);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j == 0) begin
        req_valid = '0;
        check("t5_add_a_new", add_a, 64'd7);
      end
      if (j == 5) check_rsp("t5_hit", 4'h1, 64'd15, 1'b0);
      else        check_rsp($sformatf("t5_c%0d", j), 4'h0, 64'd0, 1'b0);
    end

`ifdef SK_ADDER_ARB_STATS_EN
    // Stats: reset clears, five grants to requester 1 count to 5, reset clears again.
    pulse_reset();
    check("st_clear0", 64'(grant_cnt), 64'h0);
    set_req(1, 64'd1, 64'd1, 1'b0);
    req_valid = 4'b0010;
    repeat (5) @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("st_cnt0", 64'(grant_cnt[31:0]), 64'd0);
    check("st_cnt1", 64'(grant_cnt[63:32]), 64'd5);
    check("st_cnt2", 64'(grant_cnt[95:64]), 64'd0);
    check("st_cnt3", 64'(grant_cnt[127:96]), 64'd0);
    pulse_reset();
    check("st_clear1", 64'(grant_cnt[63:32]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sk_adder_arbiter.md
Name: sk_adder_arbiter

Overview:
Round-robin front-end that shares one pipelined 64-bit Sklansky adder (SKadder_64) among NUM_REQ requesters.
- Accepts at most one operand set per cycle and drives the adder inputs.
- Carries a requester tag down a shift pipeline matched to the adder latency.
- Steers each result back to the issuing requester.
- Sits between the client ports and the adder instance, which lives outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 64, operand/sum width
LAT, 4, adder latency: rising edges from operands applied on add_* to matching add_sum/add_cout valid
TAG_W, $clog2(NUM_REQ), requester-tag width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and rr pointer
req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NUM_REQ*WIDTH  packed operand B
req_cin  in  NUM_REQ  carry-in per requester
add_a  out  WIDTH  registered to adder a
add_b  out  WIDTH  registered to adder b
add_cin  out  1  registered to adder cin
add_sum  in  WIDTH  from adder sum
add_cout  in  1  from adder cout
rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle
rsp_sum  out  WIDTH  result sum
rsp_cout  out  1  result carry-out

Behaviour:
Reset:
- Async assert; release synchronous to clk.
- All outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first; tag pipeline valids cleared.

Arbitration:
- Search starts at pointer+1 and wraps modulo NUM_REQ.
- The first requester with req_valid set gets req_ready; at most one bit set.
- req_ready is 0 when no req_valid is set.
- Handshake = req_valid[i] & req_ready[i] at a rising edge.
- On handshake: add_a/add_b/add_cin <= req_a/b/cin of the winner; pointer <= winner; tag stage 0 <= {1, winner}.
- No handshake: add_* hold their values; pointer holds; stage 0 valid <= 0.

Tag pipeline:
- LAT+1 stages of {valid, TAG_W}, shifting every cycle with no stall; the adder cannot be stalled.
- Stage LAT is aligned with add_sum/add_cout.
- Next edge after alignment: rsp_valid <= onehot(tag) if valid, else 0; rsp_sum/rsp_cout <= add_sum/add_cout.
- rsp_sum/rsp_cout update every cycle; they are meaningful only while rsp_valid is set.
- Latency from handshake edge to rsp_valid high: LAT+1 cycles.
- Throughput: one result per cycle.

Responses:
- No backpressure; requesters must accept rsp_valid unconditionally.
- Results return in issue order.

Arithmetic:
- Plain WIDTH-bit add with carry.
- cout is carry out of the MSB.
- All-ones + 1 + cin 0 gives sum 0, cout 1.

Boundary conditions:
- Single requester holding valid: granted every cycle.
- Requester dropping valid while not granted: legal, nothing recorded.
- Pointer wraps NUM_REQ-1 -> 0.
- Reset mid-flight: in-flight results discarded, no rsp_valid after release until new handshakes mature.

Optional Feature:
SK_ADDER_ARB_STATS_EN
- Defined: adds output grant_cnt (NUM_REQ*32), one 32-bit saturating counter per requester.
- A counter increments on each handshake for that requester, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package sk_adder_pkg: WIDTH default, LAT default (must match the SKadder_64 stage count), tag-entry typedef {valid, tag}.
- Sub-module rr_arbiter (NUM_REQ): inputs req, adv, clk, rst_n; output one-hot gnt.
  - Owns the pointer.
  - adv = any handshake.
- Top level owns the operand mux, the tag pipeline and response steering.

Test Plan:
- Requester 0 only, a=0, b=200, cin=0 -> after LAT+1 cycles rsp_valid=0001, rsp_sum=200, rsp_cout=0; no other strobes.
- All four valid continuously, a=i, b=10*i -> grants 0,1,2,3,0,... one per cycle; rsp_valid rotates in the same order, sums 0,11,22,33.
- Requester 2: a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> rsp_sum=0, rsp_cout=1; then a=5, b=7, cin=1 on the next cycle -> 13, cout 0, back-to-back.
- Requesters 1 and 3 only, pointer at 3 -> 1 granted, then 3, then 1; the idle gap cycle yields rsp_valid=0 at the matching slot.
- Assert rst_n low for 1 cycle with 3 results in flight -> no rsp_valid afterwards until new requests, which mature LAT+1 cycles after grant; next grant goes to requester 0.
- With SK_ADDER_ARB_STATS_EN: 5 grants to requester 1 -> grant_cnt[63:32]=5, others 0; reset clears all.
